// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared load/store unit types: store widths, buffer entry, drain FSM states
package load_store_unit_pkg;

  localparam int unsigned LSU_ADDR_W = 32;
  localparam int unsigned LSU_DATA_W = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } store_width_t;

  typedef struct packed {
    logic [LSU_DATA_W-1:0] data;
    logic [LSU_ADDR_W-1:0] address;
    store_width_t          width;
  } store_buffer_entry_t;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_REQUEST,
    SB_WAIT_DONE
  } store_buffer_fsm_t;

endpackage

// File: rtl/store_buffer_forward.sv
// rtl/store_buffer_forward.sv - age-ordered word-granular store-to-load forwarding lookup
module store_buffer_forward
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                valid_i,
  input  store_buffer_entry_t [DEPTH-1:0] entries_i,
  input  logic [PTR_W-1:0]                wr_ptr_i,
  input  logic [LSU_ADDR_W-1:0]           address_i,
  output logic                            hit_o,
  output logic                            conflict_o,
  output logic [LSU_DATA_W-1:0]           data_o
);

  logic                match;
  logic [PTR_W-1:0]    idx;
  store_buffer_entry_t youngest;

  // Walk oldest (wr_ptr) to youngest (wr_ptr-1); the last match wins.
  always_comb begin
    match    = 1'b0;
    idx      = '0;
    youngest = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = wr_ptr_i + PTR_W'(k);
      if (valid_i[idx] && (entries_i[idx].address[LSU_ADDR_W-1:2] == address_i[LSU_ADDR_W-1:2])) begin
        match    = 1'b1;
        youngest = entries_i[idx];
      end
    end
  end

  // Anything other than an exact aligned word match must stall the load.
  assign hit_o      = match && (youngest.width == WORD) && (youngest.address == address_i);
  assign conflict_o = match && !hit_o;
  assign data_o     = hit_o ? youngest.data : '0;

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO between store unit and store controller with load forwarding
module store_buffer
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_request_i,
  input  logic [DATA_W+ADDR_W+1:0] push_packet_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ctrl_request_o,
  output logic [DATA_W-1:0]        ctrl_data_o,
  output logic [ADDR_W-1:0]        ctrl_address_o,
  output logic [1:0]               ctrl_width_o,
  input  logic                     ctrl_done_i,
  input  logic                     ctrl_idle_i,
  input  logic [ADDR_W-1:0]        fwd_address_i,
  output logic                     fwd_hit_o,
  output logic [DATA_W-1:0]        fwd_data_o,
  output logic                     fwd_conflict_o,
  output logic                     drained_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  store_buffer_entry_t [DEPTH-1:0] entries_q;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  store_buffer_fsm_t state_q, state_d;
  logic              push_en;
  logic              pop_en;
  store_buffer_entry_t head;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign drained_o = empty_o && (state_q == SB_IDLE);
  assign push_en   = push_request_i && !full_o;

  assign head           = entries_q[rd_ptr_q];
  assign ctrl_data_o    = head.data;
  assign ctrl_address_o = head.address;
  assign ctrl_width_o   = head.width;

  always_comb begin
    state_d        = state_q;
    ctrl_request_o = 1'b0;
    pop_en         = 1'b0;
    unique case (state_q)
      SB_IDLE: begin
        if (!empty_o && ctrl_idle_i) state_d = SB_REQUEST;
      end
      SB_REQUEST: begin
        ctrl_request_o = 1'b1;
        state_d        = SB_WAIT_DONE;
      end
      SB_WAIT_DONE: begin
        if (ctrl_done_i) begin
          pop_en  = 1'b1;
          state_d = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  // Push is gated by the registered full flag, so a same-cycle pop never makes room.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= SB_IDLE;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) entries_q[wr_ptr_q] <= store_buffer_entry_t'(push_packet_i);
  end

  store_buffer_forward #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_forward (
    .valid_i   (valid_q),
    .entries_i (entries_q),
    .wr_ptr_i  (wr_ptr_q),
    .address_i (fwd_address_i),
    .hit_o     (fwd_hit_o),
    .conflict_o(fwd_conflict_o),
    .data_o    (fwd_data_o)
  );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
  import load_store_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        push_request_i;
  logic [65:0] push_packet_i;
  logic        full_o, empty_o, ctrl_request_o;
  logic [31:0] ctrl_data_o, ctrl_address_o;
  logic [1:0]  ctrl_width_o;
  logic        ctrl_done_i, ctrl_idle_i;
  logic [31:0] fwd_address_i;
  logic        fwd_hit_o, fwd_conflict_o, drained_o;
  logic [31:0] fwd_data_o;

  int errors = 0;
  int checks = 0;

  store_buffer dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .push_request_i(push_request_i),
    .push_packet_i (push_packet_i),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .ctrl_request_o(ctrl_request_o),
    .ctrl_data_o   (ctrl_data_o),
    .ctrl_address_o(ctrl_address_o),
    .ctrl_width_o  (ctrl_width_o),
    .ctrl_done_i   (ctrl_done_i),
    .ctrl_idle_i   (ctrl_idle_i),
    .fwd_address_i (fwd_address_i),
    .fwd_hit_o     (fwd_hit_o),
    .fwd_data_o    (fwd_data_o),
    .fwd_conflict_o(fwd_conflict_o),
    .drained_o     (drained_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] data, input store_width_t w);
    push_request_i = 1'b1;
    push_packet_i  = {data, addr, w};
    tick();
    push_request_i = 1'b0;
  endtask

  task automatic wait_request(input string tag);
    int n = 0;
    while (!ctrl_request_o && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_req"}, ctrl_request_o, 1);
  endtask

  task automatic drain_one(input logic [31:0] exp_addr, input string tag);
    wait_request(tag);
    check({tag, "_addr"}, ctrl_address_o, exp_addr);
    tick();
    ctrl_done_i = 1'b1;
    tick();
    ctrl_done_i = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] addr, input logic hit, input logic conf,
                        input logic [31:0] data, input string tag);
    fwd_address_i = addr;
    #1;
    check({tag, "_hit"}, fwd_hit_o, hit);
    check({tag, "_conflict"}, fwd_conflict_o, conf);
    check({tag, "_data"}, fwd_data_o, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0; push_request_i = 1'b0; push_packet_i = '0;
    ctrl_done_i = 1'b0; ctrl_idle_i = 1'b0; fwd_address_i = 32'h2000;
    #1;
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_req", ctrl_request_o, 0);
    check("rst_hit", fwd_hit_o, 0);
    check("rst_conflict", fwd_conflict_o, 0);
    check("rst_drained", drained_o, 1);
    check("rst_fwd_data", fwd_data_o, 0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();

    // 1: single store, request at +2, empty at +4
    ctrl_idle_i = 1'b1;
    push(32'h2000, 32'hDEADBEEF, WORD);
    check("t1_c1_empty", empty_o, 0);
    check("t1_c1_req", ctrl_request_o, 0);
    tick();
    check("t1_c2_req", ctrl_request_o, 1);
    check("t1_c2_addr", ctrl_address_o, 32'h2000);
    check("t1_c2_data", ctrl_data_o, 32'hDEADBEEF);
    check("t1_c2_width", ctrl_width_o, 2'b10);
    tick();
    check("t1_c3_req", ctrl_request_o, 0);
    ctrl_done_i = 1'b1;
    tick();
    ctrl_done_i = 1'b0;
    check("t1_c4_empty", empty_o, 1);
    check("t1_c4_drained", drained_o, 1);

    // 2: fill, overflow push dropped, drain in order
    ctrl_idle_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(4 * i), 32'hA0 + 32'(i), WORD);
    check("t2_full", full_o, 1);
    push(32'h2010, 32'hBAD, WORD);
    check("t2_full_after5", full_o, 1);
    lookup(32'h2010, 0, 0, 0, "t2_dropped_fwd");
    lookup(32'h2008, 1, 0, 32'hA2, "t2_fwd_mid");
    ctrl_idle_i = 1'b1;
    for (int i = 0; i < 4; i++) drain_one(32'h2000 + 32'(4 * i), $sformatf("t2_drain%0d", i));
    check("t2_empty", empty_o, 1);

    // 3: full buffer, push and pop in the same cycle -> push rejected
    ctrl_idle_i = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(4 * i), 32'hC0 + 32'(i), WORD);
    ctrl_idle_i = 1'b1;
    wait_request("t3_first");
    tick();
    ctrl_idle_i    = 1'b0;
    ctrl_done_i    = 1'b1;
    push_request_i = 1'b1;
    push_packet_i  = {32'h5555, 32'h2FF0, WORD};
    tick();
    ctrl_done_i    = 1'b0;
    push_request_i = 1'b0;
    check("t3_full_after", full_o, 0);
    lookup(32'h2FF0, 0, 0, 0, "t3_rejected_fwd");
    ctrl_idle_i = 1'b1;
    for (int i = 1; i < 4; i++) drain_one(32'h2000 + 32'(4 * i), $sformatf("t3_drain%0d", i));
    check("t3_empty", empty_o, 1);

    // 4/5: forwarding youngest word, miss, and partial-width conflict
    ctrl_idle_i = 1'b0;
    push(32'h3000, 32'h11111111, WORD);
    push(32'h3000, 32'h22222222, WORD);
    lookup(32'h3000, 1, 0, 32'h22222222, "t4_hit");
    lookup(32'h3004, 0, 0, 0, "t4_miss");
    push(32'h3001, 32'h00000055, BYTE);
    lookup(32'h3000, 0, 1, 0, "t5_conflict");
    lookup(32'h3004, 0, 0, 0, "t5_miss");
    ctrl_idle_i = 1'b1;
    drain_one(32'h3000, "t5_drain0");
    drain_one(32'h3000, "t5_drain1");
    drain_one(32'h3001, "t5_drain2");
    check("t5_empty", empty_o, 1);

    // 6: wrap-around, then async reset during WAIT_DONE
    for (int i = 0; i < 10; i++) begin
      push(32'h4000 + 32'(4 * i), 32'h40 + 32'(i), WORD);
      drain_one(32'h4000 + 32'(4 * i), $sformatf("t6_wrap%0d", i));
    end
    check("t6_wrap_empty", empty_o, 1);
    push(32'h5000, 32'h5A5A5A5A, WORD);
    wait_request("t6_last");
    tick();
    lookup(32'h5000, 1, 0, 32'h5A5A5A5A, "t6_head_wait");
    check("t6_pre_drained", drained_o, 0);
    check("t6_pre_empty", empty_o, 0);
    rst_n_i = 1'b0;
    #1;
    check("t6_rst_empty", empty_o, 1);
    check("t6_rst_req", ctrl_request_o, 0);
    check("t6_rst_drained", drained_o, 1);
    check("t6_rst_hit", fwd_hit_o, 0);
    tick();
    rst_n_i = 1'b1;
    tick(); tick();
    check("t6_post_req", ctrl_request_o, 0);
    check("t6_post_empty", empty_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
